// File: rtl/alpide_io_if.sv
// Chip-side bus driven by alpide_io_seq: master clock, chip reset and DCTRL lines.
// The master modport belongs to the sequencer and the slave modport to the chip/pad side.
interface alpide_io_if #(
    parameter int NCHIPS = 4
);
    logic [NCHIPS-1:0] mclk_o;
    logic [NCHIPS-1:0] mclk_oe_o;
    logic [NCHIPS-1:0] rst_n_o;
    logic              dctrl_o;
    logic [NCHIPS-1:0] dctrl_oe_o;
    logic              pordis_n_o;

    modport master (
        output mclk_o, mclk_oe_o, rst_n_o, dctrl_o, dctrl_oe_o, pordis_n_o
    );

    modport slave (
        input mclk_o, mclk_oe_o, rst_n_o, dctrl_o, dctrl_oe_o, pordis_n_o
    );
endinterface

// File: rtl/alpide_io_seq.sv
// ALPIDE I/O sequencer: master clock divider, per-chip reset pulse and DCTRL gating.
// Sequence IDLE -> RESET (RSTLEN cycles with rst_n_o low) -> RUN, re-entered on start_i.
module alpide_io_seq #(
    parameter int NCHIPS = 4,
    parameter int CLKDIV = 1,
    parameter int RSTLEN = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [NCHIPS-1:0] chip_en_i,
    input  logic              forcezero_i,
    input  logic              dctrl_i,
    input  logic              dctrl_oe_i,
    alpide_io_if.master       io,
    output logic              alpide_phase_o,
    output logic              busy_o,
    output logic              ready_o
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CNT_W = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RSTLEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  pulse_cnt, pulse_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic              mclk_int;
    logic [NCHIPS-1:0] en_live;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt  <= '0;
            mclk_int <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            mclk_int <= ~mclk_int;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        pulse_nxt = pulse_cnt;
        if (stop_i) begin
            state_nxt = ST_IDLE;
            pulse_nxt = '0;
        end else if (start_i) begin
            state_nxt = ST_RESET;
            pulse_nxt = RST_LAST;
        end else if (state == ST_RESET) begin
            if (pulse_cnt == '0) state_nxt = ST_RUN;
            else                 pulse_nxt = pulse_cnt - 1'b1;
        end
    end

    assign en_live = chip_en_i & ~{NCHIPS{forcezero_i}};

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_IDLE;
            pulse_cnt      <= '0;
            io.mclk_o      <= '0;
            io.mclk_oe_o   <= '0;
            io.rst_n_o     <= '0;
            alpide_phase_o <= 1'b0;
            busy_o         <= 1'b0;
            ready_o        <= 1'b0;
        end else begin
            state          <= state_nxt;
            pulse_cnt      <= pulse_nxt;
            alpide_phase_o <= mclk_int;
            io.mclk_o      <= (mclk_int && state_nxt != ST_IDLE) ? en_live : '0;
            io.mclk_oe_o   <= (state_nxt != ST_IDLE) ? chip_en_i : '0;
            io.rst_n_o     <= (state_nxt == ST_RUN) ? en_live : '0;
            busy_o         <= (state_nxt == ST_RESET);
            ready_o        <= (state_nxt == ST_RUN);
        end
    end

    assign io.dctrl_o    = dctrl_i & ~forcezero_i;
    assign io.dctrl_oe_o = io.mclk_oe_o & {NCHIPS{dctrl_oe_i}};
    assign io.pordis_n_o = 1'b0;

endmodule

// File: tb/tb_alpide_io_seq.sv
// Self-checking bench for alpide_io_seq: directed sequences plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_alpide_io_seq;

    localparam int N = 4;
    localparam int C = 3;
    localparam int R = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, fz = 1'b0, dctrl = 1'b0, dctrl_oe = 1'b0;
    logic [N-1:0] en = '0;
    logic         phase, busy, ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 idle, 1 chip reset pulse, 2 run.
    int           m_mode  = 0;
    int           m_left  = 0;
    int           m_edges = 0;
    logic [N-1:0] e_mclk = '0, e_oe = '0, e_rst = '0;
    logic         e_phase = 1'b0, e_busy = 1'b0, e_ready = 1'b0;

    alpide_io_if #(.NCHIPS(N)) io ();

    alpide_io_seq #(.NCHIPS(N), .CLKDIV(C), .RSTLEN(R)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .chip_en_i      (en),
        .forcezero_i    (fz),
        .dctrl_i        (dctrl),
        .dctrl_oe_i     (dctrl_oe),
        .io             (io.master),
        .alpide_phase_o (phase),
        .busy_o         (busy),
        .ready_o        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_edges = 0;
        e_mclk = '0; e_oe = '0; e_rst = '0;
        e_phase = 1'b0; e_busy = 1'b0; e_ready = 1'b0;
    endtask

    // One rising edge with the inputs currently applied.
    task automatic model_edge();
        logic ph;
        ph = ((m_edges / C) % 2) == 1;
        m_edges++;
        if (stop) m_mode = 0;
        else if (start) begin
            m_mode = 1;
            m_left = R;
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
        e_phase = ph;
        e_oe    = (m_mode != 0) ? en : '0;
        e_mclk  = (ph && m_mode != 0 && !fz) ? en : '0;
        e_rst   = (m_mode == 2 && !fz) ? en : '0;
        e_busy  = (m_mode == 1);
        e_ready = (m_mode == 2);
    endtask

    task automatic check_all();
        check("mclk", io.mclk_o, e_mclk);
        check("mclk_oe", io.mclk_oe_o, e_oe);
        check("rst_n", io.rst_n_o, e_rst);
        check("phase", phase, e_phase);
        check("busy", busy, e_busy);
        check("ready", ready, e_ready);
        check("dctrl", io.dctrl_o, fz ? 1'b0 : dctrl);
        check("dctrl_oe", io.dctrl_oe_o, dctrl_oe ? e_oe : '0);
        check("pordis_n", io.pordis_n_o, 1'b0);
    endtask

    // Inputs are applied before the call (at a falling edge); outputs checked at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mclk"}, io.mclk_o, '0);
        check({tag, "_oe"}, io.mclk_oe_o, '0);
        check({tag, "_rst"}, io.rst_n_o, '0);
        check({tag, "_phase"}, phase, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, ready, 1'b0);
    endtask

    initial begin
        int lo;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Free-running divider while idle: mclk_o stays low, phase toggles every C cycles.
        en = 4'b1111;
        repeat (12) cycle();

        // Reset pulse with a partial enable mask.
        en = 4'b1011;
        start = 1'b1; cycle(); start = 1'b0;
        lo = 0;
        for (int k = 0; k < 100 && busy; k++) begin
            lo++;
            cycle();
        end
        check("busy_len", lo, R);
        check("run_rst", io.rst_n_o, 4'b1011);
        check("run_oe", io.mclk_oe_o, 4'b1011);
        check("run_ready", ready, 1'b1);

        // Re-reset from RUN with a second start 5 cycles later.
        lo = 0;
        for (int k = 0; k < 40; k++) begin
            start = (k == 0 || k == 5);
            cycle();
            if (io.rst_n_o == '0) lo++;
        end
        start = 1'b0;
        check("rereset_len", lo, R + 5);
        check("rereset_rst", io.rst_n_o, 4'b1011);

        // forcezero held in RUN.
        dctrl = 1'b1; dctrl_oe = 1'b1; fz = 1'b1;
        repeat (10) cycle();
        fz = 1'b0;
        repeat (4) cycle();
        check("fz_ready", ready, 1'b1);
        check("fz_oe", io.mclk_oe_o, 4'b1011);

        // start and stop together in RUN.
        start = 1'b1; stop = 1'b1; cycle();
        start = 1'b0; stop = 1'b0;
        check("stopwin_oe", io.mclk_oe_o, '0);
        check("stopwin_doe", io.dctrl_oe_o, '0);
        check("stopwin_ready", ready, 1'b0);

        // Asynchronous reset in the middle of a reset pulse.
        start = 1'b1; cycle(); start = 1'b0;
        repeat (5) cycle();
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("async_hold");
        rst_n = 1'b1;
        repeat (40) cycle();
        check("async_ready", ready, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            start    = ($urandom_range(99) < 4);
            stop     = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 6) fz = ~fz;
            if ($urandom_range(99) < 5) en = N'($urandom);
            dctrl    = $urandom_range(1);
            dctrl_oe = $urandom_range(1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
